cpu_top: RTL and testbench
==========================

// Module: cpu_top
// PURPOSE
//  Single-cycle RV32I-subset processor with private instruction and data memories.
//  Every instruction completes in one clk cycle: fetch, decode, execute, memory and writeback.
//  It is the top of the CPU design. Benches reach its internals hierarchically:
//  imem is loaded with $readmemh, and pc/instr/aluOut/memReadData/reg_file.regs are probed.
// PARAMETERS
//  IMEM_WORDS  64  depth of imem in 32-bit words
//  DMEM_WORDS  64  depth of dmem in 32-bit words
// PORTS
//  clk        in   1   single system clock; all state changes on its rising edge
//  reset      in   1   synchronous, active-high reset
//  WriteData  out  32  store data (rs2 value) presented to data memory
//  DataAdr    out  32  data memory byte address (= aluOut)
//  MemWrite   out  1   high when the current instruction is a store (sw)
// BEHAVIOUR
//  - Required internal names: reg [31:0] imem[0:IMEM_WORDS-1] (word 0 = address 0), dmem likewise,
//    wires pc, instr, aluOut, memReadData, and register-file instance reg_file holding reg [31:0] regs[0:31].
//  - Reset on a rising clk edge with reset=1:
//    - pc <= 0; regs[1..31] <= 0; dmem is not cleared.
//    - While reset is high, MemWrite=0 and no register or dmem write occurs.
//  - Fetch: instr = imem[pc[31:2]] (combinational). The index wraps modulo IMEM_WORDS; pc[1:0] is ignored.
//  - Register file: two combinational read ports and one synchronous write port.
//    - x0 always reads 0; writes to x0 are dropped.
//    - A read in the same cycle as a write returns the old value.
//  - Supported opcodes:
//    - R (0110011): add, sub, and, or, xor, slt, sltu, sll, srl, sra. Shift amount = rs2[4:0].
//    - I-ALU (0010011): addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
//    - lw (0000011, funct3 010); sw (0100011, funct3 010).
//    - beq, bne, blt, bge (1100011); jal (1101111); jalr (1100111); lui (0110111).
//  - Immediates are sign-extended (I/S/B/J types). lui places imm[31:12] with low 12 bits = 0.
//    All arithmetic is 32-bit wraparound with no overflow flags. slt/blt/bge compare signed; sltu/sltiu unsigned.
//  - Next pc:
//    - Taken branch or jal: pc + imm.
//    - jalr: (rs1 + imm) & ~1.
//    - Otherwise: pc + 4.
//  - Writeback value:
//    - jal/jalr write pc+4.
//    - lw writes memReadData = dmem[aluOut[31:2] mod DMEM_WORDS].
//    - ALU ops write aluOut.
//    - lui writes the immediate.
//  - Stores: sw writes rs2 into the dmem word at aluOut on the rising edge. Only word accesses exist;
//    misaligned addresses are truncated to the word. Store and load in the same cycle are impossible
//    (single instruction).
//  - Unknown opcode or funct: behaves as a nop (no reg/dmem write, pc+4), never hangs.
//  - Outputs: DataAdr=aluOut and WriteData=rs2 value are purely combinational, valid every cycle.
//    MemWrite = (opcode==sw) && !reset.
//  - Reset asserted mid-program aborts the current instruction: no write that cycle, pc returns to 0.
// STRUCTURE
//  - Shared package cpu_pkg: opcode constants, ALU-op enum/localparams, immediate-type enum.
//  - One natural sub-module: regfile (instance name reg_file, array regs).
//  - Decoder, ALU, immediate generator, memories and pc logic are inline in cpu_top.
// TESTING
//  - Reset: hold reset 1 cycle -> pc=0, MemWrite=0, regs x9..x13 read 0.
//  - ALU: addi x9,x0,5; addi x10,x0,-3; add x11,x9,x10; sub x12,x9,x10; slt x13,x10,x9
//    -> x9=0x5, x10=0xfffffffd, x11=0x2, x12=0x8, x13=0x1.
//  - Memory: addi x9,x0,0x2a; sw x9,8(x0)
//    -> that cycle MemWrite=1, DataAdr=0x8, WriteData=0x2a.
//    - Then lw x10,8(x0) -> x10=0x2a.
//  - Control flow: beq x0,x0,+8 skips the next instruction (pc jumps by 8); bne with equal operands
//    falls through. jal x11,+12 -> x11=pc+4, pc+=12.
//  - x0 and nop: addi x0,x0,7 -> x0 still 0. Opcode 0x0000007f -> no writes, pc advances by 4.
//  - lui x12,0x12345 -> x12=0x12345000. srai of 0x80000000 by 4 -> 0xf8000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RV32I-subset core: opcodes, ALU operations,
// immediate formats and the immediate generator used by the decoder.
package cpu_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } AluOp;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} ImmType;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} WbSel;

    // B and J offsets are stored scrambled in the instruction word; bit 0 is always zero.
    function automatic logic [31:0] genImm(input logic [31:0] ins, input ImmType immType);
        case (immType)
            IMM_I:   return {{20{ins[31]}}, ins[31:20]};
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:   return {ins[31:12], 12'd0};
            default: return {{20{ins[31]}}, ins[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/cpu_if.sv
// Register-file access bundle: two read ports and one write port between the core and regfile.
interface cpu_if;
    import cpu_pkg::*;

    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] rdData;
    logic        we;

    modport master (output rs1Addr, rs2Addr, rdAddr, rdData, we, input rs1Data, rs2Data);
    modport slave  (input rs1Addr, rs2Addr, rdAddr, rdData, we, output rs1Data, rs2Data);
endinterface

// File: rtl/cpu_regfile.sv
// 32 x 32-bit register file: combinational reads (old value during a write), synchronous write,
// x0 hard-wired to zero.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    cpu_if.slave rf
);

    logic [31:0] regs [0:31];

    assign rf.rs1Data = (rf.rs1Addr == 5'd0) ? 32'd0 : regs[rf.rs1Addr];
    assign rf.rs2Data = (rf.rs2Addr == 5'd0) ? 32'd0 : regs[rf.rs2Addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (rf.we && (rf.rdAddr != 5'd0)) begin
            regs[rf.rdAddr] <= rf.rdData;
        end
    end

endmodule

// File: rtl/cpu_top.sv
// Single-cycle RV32I-subset processor with private instruction and data memories;
// every instruction fetches, executes and writes back within one clock.
module cpu_top
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] WriteData,
    output logic [31:0] DataAdr,
    output logic        MemWrite
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] imem [0:IMEM_WORDS-1];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] aluOut;
    logic [31:0] memReadData;

    logic [IAW-1:0] w_imemIdx;
    logic [DAW-1:0] w_dmemIdx;
    logic [6:0]     w_opcode;
    logic [2:0]     w_funct3;
    logic [6:0]     w_funct7;
    logic [31:0]    w_imm, w_rs1Val, w_rs2Val, w_aluB, w_pcPlus4, w_pcNext, w_wbData;
    logic           w_regWrite, w_isSw, w_useImm, w_isBranch, w_isJal, w_isJalr, w_brTaken;
    AluOp           w_aluOp;
    ImmType         w_immType;
    WbSel           w_wbSel;

    cpu_if rfBus ();

    cpu_regfile reg_file (
        .clk   (clk),
        .reset (reset),
        .rf    (rfBus)
    );

    assign w_imemIdx = IAW'(pc[31:2] % IMEM_WORDS);
    assign instr     = imem[w_imemIdx];
    assign w_opcode  = instr[6:0];
    assign w_funct3  = instr[14:12];
    assign w_funct7  = instr[31:25];
    assign w_imm     = genImm(instr, w_immType);

    assign rfBus.rs1Addr = instr[19:15];
    assign rfBus.rs2Addr = instr[24:20];
    assign rfBus.rdAddr  = instr[11:7];
    assign rfBus.rdData  = w_wbData;
    assign rfBus.we      = w_regWrite && !reset;
    assign w_rs1Val      = rfBus.rs1Data;
    assign w_rs2Val      = rfBus.rs2Data;

    // Any opcode/funct combination not matched below leaves all enables low, i.e. a nop.
    always_comb begin
        w_regWrite = 1'b0;
        w_isSw     = 1'b0;
        w_useImm   = 1'b0;
        w_isBranch = 1'b0;
        w_isJal    = 1'b0;
        w_isJalr   = 1'b0;
        w_aluOp    = ALU_ADD;
        w_immType  = IMM_I;
        w_wbSel    = WB_ALU;
        case (w_opcode)
            OP_R: begin
                w_regWrite = 1'b1;
                case ({w_funct7, w_funct3})
                    {7'h00, 3'b000}: w_aluOp = ALU_ADD;
                    {7'h20, 3'b000}: w_aluOp = ALU_SUB;
                    {7'h00, 3'b111}: w_aluOp = ALU_AND;
                    {7'h00, 3'b110}: w_aluOp = ALU_OR;
                    {7'h00, 3'b100}: w_aluOp = ALU_XOR;
                    {7'h00, 3'b010}: w_aluOp = ALU_SLT;
                    {7'h00, 3'b011}: w_aluOp = ALU_SLTU;
                    {7'h00, 3'b001}: w_aluOp = ALU_SLL;
                    {7'h00, 3'b101}: w_aluOp = ALU_SRL;
                    {7'h20, 3'b101}: w_aluOp = ALU_SRA;
                    default:         w_regWrite = 1'b0;
                endcase
            end
            OP_I: begin
                w_regWrite = 1'b1;
                w_useImm   = 1'b1;
                case (w_funct3)
                    3'b000: w_aluOp = ALU_ADD;
                    3'b111: w_aluOp = ALU_AND;
                    3'b110: w_aluOp = ALU_OR;
                    3'b100: w_aluOp = ALU_XOR;
                    3'b010: w_aluOp = ALU_SLT;
                    3'b011: w_aluOp = ALU_SLTU;
                    3'b001: begin
                        if (w_funct7 == 7'h00) w_aluOp = ALU_SLL;
                        else                   w_regWrite = 1'b0;
                    end
                    3'b101: begin
                        if (w_funct7 == 7'h00)      w_aluOp = ALU_SRL;
                        else if (w_funct7 == 7'h20) w_aluOp = ALU_SRA;
                        else                        w_regWrite = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                if (w_funct3 == 3'b010) begin
                    w_regWrite = 1'b1;
                    w_useImm   = 1'b1;
                    w_wbSel    = WB_MEM;
                end
            end
            OP_SW: begin
                w_immType = IMM_S;
                if (w_funct3 == 3'b010) begin
                    w_isSw   = 1'b1;
                    w_useImm = 1'b1;
                end
            end
            OP_BR: begin
                w_immType  = IMM_B;
                w_isBranch = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                             (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
            end
            OP_JAL: begin
                w_regWrite = 1'b1;
                w_isJal    = 1'b1;
                w_immType  = IMM_J;
                w_wbSel    = WB_PC4;
            end
            OP_JALR: begin
                if (w_funct3 == 3'b000) begin
                    w_regWrite = 1'b1;
                    w_isJalr   = 1'b1;
                    w_useImm   = 1'b1;
                    w_wbSel    = WB_PC4;
                end
            end
            OP_LUI: begin
                w_regWrite = 1'b1;
                w_immType  = IMM_U;
                w_wbSel    = WB_IMM;
            end
            default: ;
        endcase
    end

    assign w_aluB = w_useImm ? w_imm : w_rs2Val;

    always_comb begin
        aluOut = 32'd0;
        case (w_aluOp)
            ALU_ADD:  aluOut = w_rs1Val + w_aluB;
            ALU_SUB:  aluOut = w_rs1Val - w_aluB;
            ALU_AND:  aluOut = w_rs1Val & w_aluB;
            ALU_OR:   aluOut = w_rs1Val | w_aluB;
            ALU_XOR:  aluOut = w_rs1Val ^ w_aluB;
            ALU_SLT:  aluOut = {31'd0, $signed(w_rs1Val) < $signed(w_aluB)};
            ALU_SLTU: aluOut = {31'd0, w_rs1Val < w_aluB};
            ALU_SLL:  aluOut = w_rs1Val << w_aluB[4:0];
            ALU_SRL:  aluOut = w_rs1Val >> w_aluB[4:0];
            ALU_SRA:  aluOut = $unsigned($signed(w_rs1Val) >>> w_aluB[4:0]);
            default:  aluOut = 32'd0;
        endcase
    end

    always_comb begin
        w_brTaken = 1'b0;
        if (w_isBranch) begin
            case (w_funct3)
                3'b000:  w_brTaken = (w_rs1Val == w_rs2Val);
                3'b001:  w_brTaken = (w_rs1Val != w_rs2Val);
                3'b100:  w_brTaken = ($signed(w_rs1Val) < $signed(w_rs2Val));
                3'b101:  w_brTaken = ($signed(w_rs1Val) >= $signed(w_rs2Val));
                default: w_brTaken = 1'b0;
            endcase
        end
    end

    assign w_pcPlus4 = pc + 32'd4;
    assign w_pcNext  = (w_isJal || w_brTaken) ? (pc + w_imm) :
                       w_isJalr               ? (aluOut & 32'hffff_fffe) :
                                                w_pcPlus4;

    assign w_dmemIdx   = DAW'(aluOut[31:2] % DMEM_WORDS);
    assign memReadData = dmem[w_dmemIdx];

    always_comb begin
        w_wbData = aluOut;
        case (w_wbSel)
            WB_ALU:  w_wbData = aluOut;
            WB_MEM:  w_wbData = memReadData;
            WB_PC4:  w_wbData = w_pcPlus4;
            WB_IMM:  w_wbData = w_imm;
            default: w_wbData = aluOut;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) pc <= 32'd0;
        else       pc <= w_pcNext;
    end

    // dmem survives reset; reset only suppresses the store of the aborted instruction.
    always_ff @(posedge clk) begin
        if (!reset && w_isSw) begin
            dmem[w_dmemIdx] <= w_rs2Val;
        end
    end

    assign DataAdr   = aluOut;
    assign WriteData = w_rs2Val;
    assign MemWrite  = w_isSw && !reset;

endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: an instruction-level reference model runs in lockstep with the core on
// a directed program and several random programs; a standalone regfile checks read-during-write.
module tb_cpu_top;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] WriteData;
    logic [31:0] DataAdr;
    logic        MemWrite;

    cpu_top #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .WriteData (WriteData),
        .DataAdr   (DataAdr),
        .MemWrite  (MemWrite)
    );

    cpu_if rfIf ();

    cpu_regfile uRf (
        .clk   (clk),
        .reset (reset),
        .rf    (rfIf)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] mRegs [0:31];
    logic [31:0] mDmem [0:63];
    logic [31:0] mImem [0:63];
    logic [31:0] mPc;

    bit checkEn   = 1'b0;
    bit directed  = 1'b0;
    bit prevReset = 1'b0;
    int cycIdx    = 0;

    logic [31:0] eNextPc, eWrVal, eStVal, eAdr;
    logic [4:0]  eWrIdx;
    int          eStIdx;
    bit          eWr, eSt, eAdrValid;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic pinReg(input string name, input int idx, input logic [31:0] exp);
        checkOutput({name, "_dut"}, dut.reg_file.regs[idx], exp);
        checkOutput({name, "_model"}, mRegs[idx], exp);
    endtask

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] encI(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] encB(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] encJ(input logic [4:0] rd, input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] encU(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction

    // Architectural meaning of the instruction at mPc, evaluated against the model state.
    task automatic modelEval();
        logic [31:0] ins, a, b, iI, iS, iB, iJ;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  r1, r2;
        ins = mImem[(mPc >> 2) % 64];
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        r1  = ins[19:15];
        r2  = ins[24:20];
        a   = mRegs[r1];
        b   = mRegs[r2];
        iI  = {{20{ins[31]}}, ins[31:20]};
        iS  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        iB  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iJ  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        eNextPc = mPc + 32'd4;
        eWr = 1'b0; eWrIdx = ins[11:7]; eWrVal = 32'd0;
        eSt = 1'b0; eStIdx = 0; eStVal = b;
        eAdr = 32'd0; eAdrValid = 1'b0;
        case (op)
            7'h33: begin
                eWr = 1'b1;
                case ({f7, f3})
                    10'h000: eWrVal = a + b;
                    10'h100: eWrVal = a - b;
                    10'h001: eWrVal = a << b[4:0];
                    10'h002: eWrVal = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    10'h003: eWrVal = (a < b) ? 32'd1 : 32'd0;
                    10'h004: eWrVal = a ^ b;
                    10'h005: eWrVal = a >> b[4:0];
                    10'h105: eWrVal = $unsigned($signed(a) >>> b[4:0]);
                    10'h006: eWrVal = a | b;
                    10'h007: eWrVal = a & b;
                    default: eWr = 1'b0;
                endcase
                eAdr = eWrVal; eAdrValid = eWr;
            end
            7'h13: begin
                eWr = 1'b1;
                case (f3)
                    3'd0: eWrVal = a + iI;
                    3'd2: eWrVal = ($signed(a) < $signed(iI)) ? 32'd1 : 32'd0;
                    3'd3: eWrVal = (a < iI) ? 32'd1 : 32'd0;
                    3'd4: eWrVal = a ^ iI;
                    3'd6: eWrVal = a | iI;
                    3'd7: eWrVal = a & iI;
                    3'd1: if (f7 == 7'h00) eWrVal = a << ins[24:20]; else eWr = 1'b0;
                    3'd5: begin
                        if (f7 == 7'h00)      eWrVal = a >> ins[24:20];
                        else if (f7 == 7'h20) eWrVal = $unsigned($signed(a) >>> ins[24:20]);
                        else                  eWr = 1'b0;
                    end
                endcase
                eAdr = eWrVal; eAdrValid = eWr;
            end
            7'h03: if (f3 == 3'd2) begin
                eWr = 1'b1; eAdr = a + iI; eAdrValid = 1'b1;
                eWrVal = mDmem[(eAdr >> 2) % 64];
            end
            7'h23: if (f3 == 3'd2) begin
                eSt = 1'b1; eAdr = a + iS; eAdrValid = 1'b1;
                eStIdx = (eAdr >> 2) % 64;
            end
            7'h63: begin
                if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b) ||
                    (f3 == 3'd4 && $signed(a) < $signed(b)) ||
                    (f3 == 3'd5 && $signed(a) >= $signed(b)))
                    eNextPc = mPc + iB;
            end
            7'h6f: begin
                eWr = 1'b1; eWrVal = mPc + 32'd4; eNextPc = mPc + iJ;
            end
            7'h67: if (f3 == 3'd0) begin
                eWr = 1'b1; eWrVal = mPc + 32'd4; eNextPc = (a + iI) & 32'hffff_fffe;
            end
            7'h37: begin
                eWr = 1'b1; eWrVal = {ins[31:12], 12'd0};
            end
            default: ;
        endcase
    endtask

    task automatic modelCommit();
        if (eWr && eWrIdx != 5'd0) mRegs[eWrIdx] = eWrVal;
        if (eSt) mDmem[eStIdx] = eStVal;
        mPc = eNextPc;
    endtask

    task automatic directedChecks();
        case (cycIdx)
            5: begin
                checkOutput("aluPc", dut.pc, 32'd20);
                pinReg("addiX9", 9, 32'h5);
                pinReg("addiX10", 10, 32'hffff_fffd);
                pinReg("addX11", 11, 32'h2);
                pinReg("subX12", 12, 32'h8);
                pinReg("sltX13", 13, 32'h1);
            end
            6: begin
                checkOutput("swMemWrite", {31'd0, MemWrite}, 32'd1);
                checkOutput("swDataAdr", DataAdr, 32'h8);
                checkOutput("swWriteData", WriteData, 32'h2a);
            end
            9: begin
                checkOutput("beqSkipPc", dut.pc, 32'd40);
                pinReg("lwX10", 10, 32'h2a);
            end
            10: checkOutput("bneFallPc", dut.pc, 32'd44);
            11: begin
                checkOutput("jalPc", dut.pc, 32'd56);
                pinReg("jalX11", 11, 32'd48);
            end
            13: begin
                checkOutput("nopPc", dut.pc, 32'd64);
                pinReg("x0Kept", 0, 32'd0);
            end
            17: begin
                checkOutput("haltPc", dut.pc, 32'd76);
                pinReg("luiX12", 12, 32'h1234_5000);
                pinReg("luiX16", 16, 32'h8000_0000);
                pinReg("sraiX17", 17, 32'hf800_0000);
                pinReg("skipX14", 14, 32'd0);
                pinReg("skipX15", 15, 32'd0);
            end
            default: ;
        endcase
    endtask

    // Single compare process: sampled on the falling edge, between the core's update edges.
    always @(negedge clk) begin
        if (checkEn) begin
            if (reset) begin
                checkOutput("resetMemWrite", {31'd0, MemWrite}, 32'd0);
                if (prevReset) begin
                    checkOutput("resetPc", dut.pc, 32'd0);
                    for (int i = 9; i <= 13; i++) begin
                        checkOutput($sformatf("resetX%0d", i), dut.reg_file.regs[i], 32'd0);
                    end
                end
                mPc = 32'd0;
                for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
                cycIdx = 0;
            end else begin
                if (directed) directedChecks();
                modelEval();
                checkOutput("pc", dut.pc, mPc);
                checkOutput("MemWrite", {31'd0, MemWrite}, {31'd0, eSt});
                checkOutput("WriteData", WriteData, eStVal);
                if (eAdrValid) checkOutput("DataAdr", DataAdr, eAdr);
                for (int i = 1; i < 32; i++) begin
                    checkOutput($sformatf("x%0d", i), dut.reg_file.regs[i], mRegs[i]);
                end
                modelCommit();
                cycIdx++;
            end
        end
        prevReset = reset;
    end

    function automatic logic [31:0] randInstr();
        logic [4:0]  rd  = 5'($urandom_range(0, 15));
        logic [4:0]  r1  = 5'($urandom_range(0, 15));
        logic [4:0]  r2  = 5'($urandom_range(0, 15));
        logic [11:0] imm = 12'($urandom);
        logic [2:0]  f3  = 3'($urandom);
        int          off = (int'($urandom_range(0, 16)) - 8) * 4;
        case ($urandom_range(0, 11))
            0:  return encR(7'h00, r2, r1, f3, rd);
            1:  return encR(7'h20, r2, r1, f3, rd);
            2:  return encI(7'h13, rd, f3, r1, imm);
            3:  return encI(7'h13, rd, 3'd5, r1, {7'h20, imm[4:0]});
            4:  return encI(7'h03, rd, 3'd2, r1, imm);
            5:  return encS(r2, r1, imm);
            6:  return encB({f3[1], 1'b0, f3[0]}, r1, r2, 13'(off));
            7:  return encJ(rd, 21'(off));
            8:  return encI(7'h67, rd, 3'd0, r1, 12'(off));
            9:  return encU(rd, 20'($urandom));
            10: return $urandom;
            default: return encB(f3, r1, r2, 13'(off));
        endcase
    endfunction

    // Reload both memories under reset with a random program, then run it with one
    // reset pulse dropped in at a random point mid-program.
    task automatic applyStimulus(input int cycles);
        logic [31:0] w;
        int          resetAt;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            w = randInstr();
            dut.imem[i] = w;
            mImem[i]    = w;
            w = $urandom;
            dut.dmem[i] = w;
            mDmem[i]    = w;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        resetAt = $urandom_range(cycles / 4, (3 * cycles) / 4);
        repeat (resetAt) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (cycles - resetAt) @(posedge clk);
    endtask

    task automatic loadDirected();
        logic [31:0] prog [0:63];
        for (int i = 0; i < 64; i++) prog[i] = encJ(5'd0, 21'd0);
        prog[0]  = encI(7'h13, 5'd9, 3'd0, 5'd0, 12'd5);
        prog[1]  = encI(7'h13, 5'd10, 3'd0, 5'd0, 12'hffd);
        prog[2]  = encR(7'h00, 5'd10, 5'd9, 3'd0, 5'd11);
        prog[3]  = encR(7'h20, 5'd10, 5'd9, 3'd0, 5'd12);
        prog[4]  = encR(7'h00, 5'd9, 5'd10, 3'd2, 5'd13);
        prog[5]  = encI(7'h13, 5'd9, 3'd0, 5'd0, 12'h02a);
        prog[6]  = encS(5'd9, 5'd0, 12'd8);
        prog[7]  = encI(7'h03, 5'd10, 3'd2, 5'd0, 12'd8);
        prog[8]  = encB(3'd0, 5'd0, 5'd0, 13'd8);
        prog[9]  = encI(7'h13, 5'd14, 3'd0, 5'd0, 12'd1);
        prog[10] = encB(3'd1, 5'd0, 5'd0, 13'd8);
        prog[11] = encJ(5'd11, 21'd12);
        prog[12] = encI(7'h13, 5'd15, 3'd0, 5'd0, 12'd1);
        prog[13] = encI(7'h13, 5'd15, 3'd0, 5'd0, 12'd2);
        prog[14] = encI(7'h13, 5'd0, 3'd0, 5'd0, 12'd7);
        prog[15] = 32'h0000_007f;
        prog[16] = encU(5'd12, 20'h12345);
        prog[17] = encU(5'd16, 20'h80000);
        prog[18] = encI(7'h13, 5'd17, 3'd5, 5'd16, 12'h404);
        for (int i = 0; i < 64; i++) begin
            dut.imem[i] = prog[i];
            mImem[i]    = prog[i];
            dut.dmem[i] = 32'd0;
            mDmem[i]    = 32'd0;
        end
    endtask

    initial begin
        rfIf.we      = 1'b0;
        rfIf.rdAddr  = 5'd0;
        rfIf.rdData  = 32'd0;
        rfIf.rs1Addr = 5'd0;
        rfIf.rs2Addr = 5'd0;
        loadDirected();
        checkEn  = 1'b1;
        directed = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        rfIf.we = 1'b1; rfIf.rdAddr = 5'd5; rfIf.rdData = 32'h1234; rfIf.rs1Addr = 5'd5;
        #1 checkOutput("rfOldRead", rfIf.rs1Data, 32'd0);
        @(posedge clk);
        #1 checkOutput("rfNewRead", rfIf.rs1Data, 32'h1234);
        rfIf.rdAddr = 5'd0; rfIf.rdData = 32'hffff_ffff; rfIf.rs1Addr = 5'd0; rfIf.rs2Addr = 5'd5;
        @(posedge clk);
        #1 checkOutput("rfX0Read", rfIf.rs1Data, 32'd0);
        checkOutput("rfPort2Read", rfIf.rs2Data, 32'h1234);
        rfIf.we = 1'b0;

        repeat (20) @(posedge clk);
        #1 directed = 1'b0;

        for (int p = 0; p < 4; p++) applyStimulus(300);

        @(posedge clk);
        #1 $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
